fft_butterfly_pipe: RTL

FFT_BUTTERFLY_PIPE -- requirements
Module: fft_butterfly_pipe

---
 rtl/fft_butterfly_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly x = (a + b*W)/2, y = (a - b*W)/2 with a 3-stage
// valid/ready pipeline, Q2.14 twiddles from an external ROM, and saturation.
module fft_butterfly_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  input  logic        [3:0]       tw_idx,
  output logic        [3:0]       tw_addr,
  input  logic signed [WIDTH-1:0] wr,
  input  logic signed [WIDTH-1:0] wi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_re,
  output logic signed [WIDTH-1:0] x_im,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im,
  output logic                    sat
);

  localparam int unsigned LATENCY = 3;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned AW = SW + 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic               en;
  logic [LATENCY-1:0] vld_q, vld_d;

  logic signed [WIDTH-1:0] a_re1_q, a_im1_q, b_re1_q, b_im1_q, wr1_q, wi1_q;
  logic signed [WIDTH-1:0] a_re2_q, a_im2_q;
  logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  logic signed [SW-1:0] t_re_full, t_im_full, t_re, t_im;
  logic signed [AW-1:0] sum_xr, sum_xi, sum_yr, sum_yi;
  logic        [WIDTH:0] res_xr, res_xi, res_yr, res_yi;

  logic signed [WIDTH-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic signed [WIDTH-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
  logic                    sat_q, sat_d;

  // Returns {clipped, value}.
  function automatic logic [WIDTH:0] clip_f(input logic signed [AW-1:0] v);
    if (v > MAXV)      return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    else if (v < MINV) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else               return {1'b0, v[WIDTH-1:0]};
  endfunction

  assign en        = !vld_q[LATENCY-1] || out_ready;
  assign in_ready  = en;
  assign tw_addr   = tw_idx;
  assign out_valid = vld_q[LATENCY-1];
  assign vld_d     = {vld_q[LATENCY-2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= vld_d;
  end

  // S1: operands and twiddle, sampled together
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      a_re1_q <= a_re;
      a_im1_q <= a_im;
      b_re1_q <= b_re;
      b_im1_q <= b_im;
      wr1_q   <= wr;
      wi1_q   <= wi;
    end
  end

  // S2: full-precision partial products
  always_ff @(posedge clk) begin
    if (en && vld_q[0]) begin
      a_re2_q <= a_re1_q;
      a_im2_q <= a_im1_q;
      p_rr_q  <= PW'(b_re1_q) * PW'(wr1_q);
      p_ii_q  <= PW'(b_im1_q) * PW'(wi1_q);
      p_ri_q  <= PW'(b_re1_q) * PW'(wi1_q);
      p_ir_q  <= PW'(b_im1_q) * PW'(wr1_q);
    end
  end

  // S3 combine: floor shifts throughout, t kept wide so a+t cannot wrap
  always_comb begin
    t_re_full = SW'(p_rr_q) - SW'(p_ii_q);
    t_im_full = SW'(p_ri_q) + SW'(p_ir_q);
    t_re      = t_re_full >>> (WIDTH - 2);
    t_im      = t_im_full >>> (WIDTH - 2);
    sum_xr    = (AW'(a_re2_q) + AW'(t_re)) >>> 1;
    sum_xi    = (AW'(a_im2_q) + AW'(t_im)) >>> 1;
    sum_yr    = (AW'(a_re2_q) - AW'(t_re)) >>> 1;
    sum_yi    = (AW'(a_im2_q) - AW'(t_im)) >>> 1;
    res_xr    = clip_f(sum_xr);
    res_xi    = clip_f(sum_xi);
    res_yr    = clip_f(sum_yr);
    res_yi    = clip_f(sum_yi);
    x_re_d    = res_xr[WIDTH-1:0];
    x_im_d    = res_xi[WIDTH-1:0];
    y_re_d    = res_yr[WIDTH-1:0];
    y_im_d    = res_yi[WIDTH-1:0];
    sat_d     = res_xr[WIDTH] | res_xi[WIDTH] | res_yr[WIDTH] | res_yi[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
      sat_q  <= 1'b0;
    end else if (en && vld_q[1]) begin
      x_re_q <= x_re_d;
      x_im_q <= x_im_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
      sat_q  <= sat_d;
    end
  end

  assign x_re = x_re_q;
  assign x_im = x_im_q;
  assign y_re = y_re_q;
  assign y_im = y_im_q;
  assign sat  = sat_q;

endmodule
